// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared definitions for the iterative multiply/divide unit.
//                Holds the operation encodings and the controller state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

   // Operation encodings carried on the op field of the request.
   typedef logic [1:0] muldiv_op_t;

   localparam muldiv_op_t OP_MULT  = 2'b00;
   localparam muldiv_op_t OP_MULTU = 2'b01;
   localparam muldiv_op_t OP_DIV   = 2'b10;
   localparam muldiv_op_t OP_DIVU  = 2'b11;

   // Controller states, explicitly encoded so the register width is fixed.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : Request/response bundle between the control unit and the
//                multiply/divide coprocessor.
//                Requester -> unit : start, op, a, b
//                Unit -> requester : busy, done, hi, lo, div_zero
//                master modport : control unit side
//                slave modport  : coprocessor side
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
   parameter int WIDTH = 32
);
   import muldiv_pkg::*;

   logic             start;
   muldiv_op_t       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo, div_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo, div_zero
   );

endinterface
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_signfix
//  Description : Combinational conditional two's-complement negate. Used both
//                to take operand magnitudes and to restore result signs.
//  Ports       : i_value  - input word
//                i_negate - 1: output is -i_value, 0: output is i_value
//                o_result - corrected word
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_signfix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_negate,
   output logic [WIDTH-1:0] o_result
);

   assign o_result = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative signed/unsigned multiply and divide coprocessor
//                feeding the HI/LO registers. One shift-add (multiply) or
//                restoring shift-subtract (divide) step per cycle, followed by
//                a sign-correction cycle and a one-cycle done pulse.
//  Ports       : clk   - system clock, rising edge
//                reset - synchronous active-low reset
//                bus   - muldiv_if.slave (start/op/a/b in, busy/done/hi/lo/
//                        div_zero out)
//  Options     : MULDIV_EARLY_OUT_EN - when defined, a multiply with a zero
//                operand skips the iteration phase (IDLE -> FIX -> DONE).
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic    clk,
   input  logic    reset,
   muldiv_if.slave bus
);

   muldiv_state_t      r_state;
   logic               r_isDiv;
   logic               r_negRes;     // quotient / product must be negated
   logic               r_negRem;     // remainder takes the dividend's sign
   logic [WIDTH-1:0]   r_aMag;
   logic [WIDTH-1:0]   r_bMag;
   // Multiply: full 2W product accumulator (multiplier shifts out of bit 0).
   // Divide: low half holds the dividend shifting out / quotient shifting in.
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_rem;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_divZero;

   // ---------------------------------------------------------------- request
   logic             w_startDiv;
   logic             w_startSigned;
   logic             w_bZero;
   logic             w_earlyOut;
   logic [WIDTH-1:0] w_aMag;
   logic [WIDTH-1:0] w_bMag;

   assign w_startDiv    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
   assign w_startSigned = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign w_bZero       = (bus.b == '0);

`ifdef MULDIV_EARLY_OUT_EN
   assign w_earlyOut = !w_startDiv && ((bus.a == '0) || w_bZero);
`else
   assign w_earlyOut = 1'b0;
`endif

   muldiv_signfix #(.WIDTH(WIDTH)) u_aMag (
      .i_value  (bus.a),
      .i_negate (w_startSigned & bus.a[WIDTH-1]),
      .o_result (w_aMag)
   );

   muldiv_signfix #(.WIDTH(WIDTH)) u_bMag (
      .i_value  (bus.b),
      .i_negate (w_startSigned & bus.b[WIDTH-1]),
      .o_result (w_bMag)
   );

   // ------------------------------------------------------- iteration step
   logic [WIDTH:0]     w_mulSum;
   logic [2*WIDTH-1:0] w_mulNext;
   logic [WIDTH:0]     w_remShift;
   logic               w_remGe;
   logic [WIDTH-1:0]   w_remDiff;

   assign w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + {1'b0, (r_acc[0] ? r_aMag : {WIDTH{1'b0}})};
   // The carry out of the add becomes the new top bit as everything shifts right.
   assign w_mulNext  = {w_mulSum, r_acc[WIDTH-1:1]};

   // Shifted partial remainder needs W+1 bits; after a successful subtract
   // the result is below the divisor, so W bits of difference suffice.
   assign w_remShift = {r_rem, r_acc[WIDTH-1]};
   assign w_remGe    = (w_remShift >= {1'b0, r_bMag});
   assign w_remDiff  = w_remShift[WIDTH-1:0] - r_bMag;

   // ------------------------------------------------------- sign correction
   logic [2*WIDTH-1:0] w_prodFix;
   logic [WIDTH-1:0]   w_quoFix;
   logic [WIDTH-1:0]   w_remFix;

   muldiv_signfix #(.WIDTH(2*WIDTH)) u_prodFix (
      .i_value  (r_acc),
      .i_negate (r_negRes),
      .o_result (w_prodFix)
   );

   muldiv_signfix #(.WIDTH(WIDTH)) u_quoFix (
      .i_value  (r_acc[WIDTH-1:0]),
      .i_negate (r_negRes),
      .o_result (w_quoFix)
   );

   muldiv_signfix #(.WIDTH(WIDTH)) u_remFix (
      .i_value  (r_rem),
      .i_negate (r_negRem),
      .o_result (w_remFix)
   );

   // ------------------------------------------------------------ controller
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_isDiv   <= 1'b0;
         r_negRes  <= 1'b0;
         r_negRem  <= 1'b0;
         r_aMag    <= '0;
         r_bMag    <= '0;
         r_acc     <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_divZero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_isDiv   <= w_startDiv;
                  r_negRes  <= w_startSigned & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  r_negRem  <= w_startSigned & bus.a[WIDTH-1];
                  r_aMag    <= w_aMag;
                  r_bMag    <= w_bMag;
                  r_rem     <= '0;
                  r_cnt     <= CNT_W'(WIDTH);
                  r_divZero <= 1'b0;
                  if (w_startDiv) begin
                     r_acc <= {{WIDTH{1'b0}}, w_aMag};
                  end else begin
                     r_acc <= {{WIDTH{1'b0}}, w_bMag};
                  end
                  if (w_startDiv && w_bZero) begin
                     // hi/lo are left untouched; only the flag reports.
                     r_divZero <= 1'b1;
                     r_state   <= DONE;
                  end else if (w_earlyOut) begin
                     r_acc   <= '0;
                     r_state <= FIX;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               if (r_isDiv) begin
                  r_rem            <= w_remGe ? w_remDiff : w_remShift[WIDTH-1:0];
                  r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_remGe};
               end else begin
                  r_acc <= w_mulNext;
               end
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               if (r_isDiv) begin
                  r_hi <= w_remFix;
                  r_lo <= w_quoFix;
               end else begin
                  r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prodFix[WIDTH-1:0];
               end
               r_state <= DONE;
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = (r_state == CALC) || (r_state == FIX);
   assign bus.done     = (r_state == DONE);
   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;
   assign bus.div_zero = r_divZero;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit (WIDTH=32). Expected
//                results come from a native-arithmetic reference model and
//                are queued when a request is issued, then compared when the
//                unit raises done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int WIDTH        = 32;
   localparam int CYCLE_BUDGET = 60;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } expect_t;

   logic        clk = 1'b0;
   logic        reset;
   int          checkCount = 0;
   int          failCount  = 0;
   expect_t     sbQ[$];
   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;
   logic [31:0] obsHi;
   logic [31:0] obsLo;

   muldiv_if #(.WIDTH(WIDTH)) bus ();

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference model: compute the expected outcome and queue it.
   task automatic pushExpect(input logic [1:0] o, input logic [31:0] x,
                             input logic [31:0] y);
      expect_t     e;
      longint      sx, sy, sq, sr;
      logic [63:0] ux, uy, r64;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      e.hi  = mHi;
      e.lo  = mLo;
      e.dz  = 1'b0;
      e.lat = WIDTH + 2;
      case (o)
         OP_MULT: begin
            sq  = sx * sy;
            r64 = sq;
            e.hi = r64[63:32];
            e.lo = r64[31:0];
`ifdef MULDIV_EARLY_OUT_EN
            if (x == 0 || y == 0) e.lat = 2;
`endif
         end
         OP_MULTU: begin
            r64 = ux * uy;
            e.hi = r64[63:32];
            e.lo = r64[31:0];
`ifdef MULDIV_EARLY_OUT_EN
            if (x == 0 || y == 0) e.lat = 2;
`endif
         end
         OP_DIV: begin
            if (y == 0) begin
               e.dz  = 1'b1;
               e.lat = 1;
            end else begin
               sq = sx / sy;
               sr = sx % sy;
               r64 = sq;
               e.lo = r64[31:0];
               r64 = sr;
               e.hi = r64[31:0];
            end
         end
         default: begin
            if (y == 0) begin
               e.dz  = 1'b1;
               e.lat = 1;
            end else begin
               r64 = ux / uy;
               e.lo = r64[31:0];
               r64 = ux % uy;
               e.hi = r64[31:0];
            end
         end
      endcase
      if (!e.dz) begin
         mHi = e.hi;
         mLo = e.lo;
      end
      sbQ.push_back(e);
   endtask

   // Issue one request from a negedge with the unit idle, wait for done,
   // compare, then pulse start during done (must be ignored).
   task automatic runOp(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
      expect_t e;
      int      busyCycles;
      bit      seen;
      busyCycles = 0;
      seen       = 1'b0;
      pushExpect(o, x, y);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op    = 2'($urandom);
      bus.a     = $urandom;
      bus.b     = $urandom;
      for (int cyc = 1; cyc <= CYCLE_BUDGET && !seen; cyc++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            e = sbQ.pop_front();
            checkValue("latency",    cyc,          e.lat);
            checkValue("busyCycles", busyCycles,   e.lat - 1);
            checkValue("busyAtDone", bus.busy,     1'b0);
            checkValue("hi",         bus.hi,       e.hi);
            checkValue("lo",         bus.lo,       e.lo);
            checkValue("divZero",    bus.div_zero, e.dz);
            obsHi = bus.hi;
            obsLo = bus.lo;
         end else begin
            if (bus.busy) busyCycles++;
            if (cyc == 1) checkValue("divZeroClear", bus.div_zero, 1'b0);
         end
      end
      if (!seen) begin
         checkValue("doneTimeout", seen, 1'b1);
         sbQ.delete(0);
      end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checkValue("startAtDoneIgnored", {bus.busy, bus.done}, 2'b00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sawDone;
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      checkValue("rstBusy",    bus.busy,     1'b0);
      checkValue("rstDone",    bus.done,     1'b0);
      checkValue("rstDivZero", bus.div_zero, 1'b0);
      checkValue("rstHi",      bus.hi,       32'h0);
      checkValue("rstLo",      bus.lo,       32'h0);
      reset = 1'b1;

      runOp(OP_MULT, 32'hFFFFFFFD, 32'd7);
      checkValue("planMultHi", obsHi, 32'hFFFFFFFF);
      checkValue("planMultLo", obsLo, 32'hFFFFFFEB);
      runOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      checkValue("planMultuHi", obsHi, 32'hFFFFFFFE);
      checkValue("planMultuLo", obsLo, 32'h00000001);
      runOp(OP_DIV, 32'hFFFFFFF9, 32'd2);
      checkValue("planDivLo", obsLo, 32'hFFFFFFFD);
      checkValue("planDivHi", obsHi, 32'hFFFFFFFF);
      runOp(OP_DIVU, 32'd100, 32'd7);
      checkValue("planDivuLo", obsLo, 32'd14);
      checkValue("planDivuHi", obsHi, 32'd2);
      runOp(OP_DIV, 32'd5, 32'd0);
      checkValue("planDivZeroLoKept", obsLo, 32'd14);
      checkValue("planDivZeroHiKept", obsHi, 32'd2);
      runOp(OP_DIVU, 32'd9, 32'd3);
      checkValue("planDivu93Lo", obsLo, 32'd3);
      checkValue("planDivu93Hi", obsHi, 32'd0);
      runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      checkValue("planOvfLo", obsLo, 32'h80000000);
      checkValue("planOvfHi", obsHi, 32'h0);
      runOp(OP_MULTU, 32'd0, 32'd5);
      checkValue("zeroMultLo", obsLo, 32'h0);
      runOp(OP_MULT, 32'h80000000, 32'h80000000);
      runOp(OP_DIV, 32'd7, 32'hFFFFFFFE);

      for (int i = 0; i < 8; i++) begin
         logic [1:0]  rop;
         logic [31:0] ra, rb;
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
         if (i == 4) rb = -rb;
         runOp(rop, ra, rb);
      end

      // Give hi/lo a known non-zero value before the abort.
      runOp(OP_MULTU, 32'h1234, 32'h10);

      // Abort: start a multiply, re-pulse start at cycle 10, reset at 20.
      sawDone   = 0;
      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.a     = 32'd11;
      bus.b     = 32'd13;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.done) sawDone++;
         if (c == 10) begin
            bus.start = 1'b1;
            bus.a     = 32'd2;
            bus.b     = 32'd2;
         end
         if (c == 11) bus.start = 1'b0;
         if (c == 15) checkValue("abortBusyMid", bus.busy, 1'b1);
         if (c == 20) reset = 1'b0;
         if (c == 21) begin
            reset = 1'b1;
            checkValue("abortBusy", bus.busy, 1'b0);
            checkValue("abortHi",   bus.hi,   32'h0);
            checkValue("abortLo",   bus.lo,   32'h0);
         end
      end
      checkValue("abortNoDone", sawDone, 0);
      mHi = '0;
      mLo = '0;

      runOp(OP_MULT, 32'd6, 32'd7);
      checkValue("postAbortLo", obsLo, 32'd42);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
`default_nettype wire
